// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned INSTR_W = 18;

  localparam logic [3:0]        FINISH_OP   = 4'b0110;
  localparam logic [1:0]        FETCH_DEPTH = 2'd2;
  localparam logic [ADDR_W-1:0] PC_STEP     = 18'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // A FINISH word is identified purely by its top opcode nibble
  function automatic logic is_finish(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1:INSTR_W-4] == FINISH_OP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry shift FIFO of {instr, pc} between fetch and decode
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  output logic [1:0]         count,
  output logic               head_valid,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc
);

  logic [INSTR_W-1:0] r_instr0, r_instr1;
  logic [ADDR_W-1:0]  r_pc0, r_pc1;
  logic [1:0]         r_count;
  logic               w_pop;
  logic               w_push;

  // Slot 0 is always the head; when the FIFO empties it keeps the last
  // delivered entry so decode sees stable instr/instr_pc values.
  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != FETCH_DEPTH) || w_pop);

  // Storage and occupancy update; flush drops contents but leaves data intact
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr0 <= '0;
      r_instr1 <= '0;
      r_pc0    <= '0;
      r_pc1    <= '0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        if (r_count == 2'd2) begin
          r_instr0 <= r_instr1;
          r_pc0    <= r_pc1;
          if (w_push) begin
            r_instr1 <= push_instr;
            r_pc1    <= push_pc;
          end
        end else if (w_push) begin
          r_instr0 <= push_instr;
          r_pc0    <= push_pc;
        end
      end else if (w_push) begin
        if (r_count == 2'd0) begin
          r_instr0 <= push_instr;
          r_pc0    <= push_pc;
        end else begin
          r_instr1 <= push_instr;
          r_pc1    <= push_pc;
        end
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign count      = r_count;
  assign head_valid = (r_count != 2'd0);
  assign head_instr = r_instr0;
  assign head_pc    = r_pc0;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program counter, fetch state machine and FINISH detection
module instruction_fetch
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rd,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               busy,
  output logic               halted
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;

  logic [1:0]        w_count;
  logic              w_active;
  logic              w_redir;
  logic              w_start;
  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_finish_pop;
  logic [ADDR_W-1:0] w_target;

  // Redirect is honoured only while running; start only while stopped.
  // The fetch decision looks at the registered count so instr_ready never
  // reaches imem_addr combinationally.
  assign w_active     = (r_state == FETCH) || (r_state == DRAIN);
  assign w_redir      = redirect && w_active;
  assign w_start      = start && !w_active;
  assign w_flush      = w_redir || w_start;
  assign w_push       = (r_state == FETCH) && (w_count < FETCH_DEPTH) && !w_redir;
  assign w_pop        = instr_valid && instr_ready;
  assign w_finish_pop = w_pop && is_finish(instr);
  assign w_target     = redirect_pc & ~(ADDR_W'(3));

  // State and pc: redirect beats start, both beat normal fetch/drain progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else if (w_redir) begin
      r_state <= FETCH;
      r_pc    <= w_target;
    end else if (w_start) begin
      r_state <= FETCH;
      r_pc    <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_push) begin
            if (is_finish(imem_rd)) begin
              r_state <= DRAIN;
            end else begin
              r_pc <= r_pc + PC_STEP;
            end
          end
        end
        DRAIN: begin
          if (w_finish_pop) begin
            r_state <= HALT;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .pop        (w_pop),
    .flush      (w_flush),
    .push_instr (imem_rd),
    .push_pc    (r_pc),
    .count      (w_count),
    .head_valid (instr_valid),
    .head_instr (instr),
    .head_pc    (instr_pc)
  );

  assign imem_addr = r_pc;
  assign busy      = w_active;
  assign halted    = (r_state == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [17:0] imem_addr;
  logic [17:0] imem_rd;
  logic [17:0] instr;
  logic [17:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [17:0] redirect_pc = '0;
  logic        busy;
  logic        halted;

  int ntests = 0;
  int nfail  = 0;
  int finish_idx = -1;

  logic [17:0] got_pc[$];
  logic [17:0] got_in[$];
  logic [17:0] exp_pc[$];
  logic [17:0] exp_in[$];

  localparam logic [17:0] FIN_WORD = {4'b0110, 14'h00AA};

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .busy        (busy),
    .halted      (halted)
  );

  function automatic logic [17:0] rom_word(input logic [17:0] addr);
    logic [15:0] idx;
    idx = addr[17:2];
    if (int'(idx) == finish_idx) return FIN_WORD;
    return {4'b0001, idx[13:0]};
  endfunction

  always_comb imem_rd = rom_word(imem_addr);

  task automatic step();
    if (instr_valid && instr_ready && !reset) begin
      got_pc.push_back(instr_pc);
      got_in.push_back(instr);
    end
    @(negedge clk);
  endtask

  task automatic expect_pc(input logic [17:0] pc);
    exp_pc.push_back(pc);
    exp_in.push_back(rom_word(pc));
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    got_pc.delete(); got_in.delete(); exp_pc.delete(); exp_in.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    ntests++; if (imem_addr !== 18'h0) begin nfail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    ntests++; if (instr !== 18'h0 || instr_pc !== 18'h0) begin nfail++; $display("FAIL rst_head: got %h/%h want 0/0", instr, instr_pc); end
    ntests++; if (instr_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin nfail++; $display("FAIL rst_flags: got v%b b%b h%b want 000", instr_valid, busy, halted); end
  endtask

  task automatic test_straight();
    do_reset();
    instr_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) expect_pc(18'(4 * i));
    step(); start = 1'b0;
    ntests++; if (busy !== 1'b1 || imem_addr !== 18'h0 || instr_valid !== 1'b0) begin nfail++; $display("FAIL str_cycle1: got b%b a%h v%b want 1 0 0", busy, imem_addr, instr_valid); end
    step();
    ntests++; if (instr_valid !== 1'b1 || instr_pc !== 18'h0) begin nfail++; $display("FAIL str_cycle2: got v%b pc%h want 1 0", instr_valid, instr_pc); end
    for (int i = 0; i < 4; i++) step();
    ntests++; if (got_pc.size() != 4) begin nfail++; $display("FAIL str_count: got %0d want 4", got_pc.size()); end
    for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
      ntests++; if (got_pc[i] !== exp_pc[i] || got_in[i] !== exp_in[i]) begin nfail++; $display("FAIL str_item%0d: got %h@%h want %h@%h", i, got_in[i], got_pc[i], exp_in[i], exp_pc[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    ntests++; if (imem_addr !== 18'h8 || instr_valid !== 1'b1 || instr_pc !== 18'h0) begin nfail++; $display("FAIL bp_stall: got a%h v%b pc%h want 8 1 0", imem_addr, instr_valid, instr_pc); end
    for (int i = 0; i < 3; i++) expect_pc(18'(4 * i));
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    ntests++; if (got_pc.size() != 3) begin nfail++; $display("FAIL bp_count: got %0d want 3", got_pc.size()); end
    for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
      ntests++; if (got_pc[i] !== exp_pc[i]) begin nfail++; $display("FAIL bp_item%0d: got %h want %h", i, got_pc[i], exp_pc[i]); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    expect_pc(18'h0);
    instr_ready = 1'b1; step();
    instr_ready = 1'b0; step();
    ntests++; if (instr_pc !== 18'h4 || imem_addr !== 18'hC) begin nfail++; $display("FAIL rd_setup: got pc%h a%h want 4 c", instr_pc, imem_addr); end
    redirect = 1'b1; redirect_pc = 18'h00017; step(); redirect = 1'b0;
    ntests++; if (instr_valid !== 1'b0 || imem_addr !== 18'h14) begin nfail++; $display("FAIL rd_flush: got v%b a%h want 0 14", instr_valid, imem_addr); end
    expect_pc(18'h14);
    instr_ready = 1'b1; step(); step();
    ntests++; if (got_pc.size() != 2) begin nfail++; $display("FAIL rd_count: got %0d want 2", got_pc.size()); end
    for (int i = 0; i < 2 && i < got_pc.size(); i++) begin
      ntests++; if (got_pc[i] !== exp_pc[i] || got_in[i] !== exp_in[i]) begin nfail++; $display("FAIL rd_item%0d: got %h@%h want %h@%h", i, got_in[i], got_pc[i], exp_in[i], exp_pc[i]); end
    end
  endtask

  task automatic test_finish();
    logic pf;
    logic pre_h;
    logic seen;
    do_reset();
    finish_idx = 29;
    instr_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 60 && imem_addr !== 18'h74; k++) step();
    ntests++; if (imem_addr !== 18'h74) begin nfail++; $display("FAIL fin_reach: got %h want 74", imem_addr); end
    instr_ready = 1'b0;
    step(); step(); step();
    ntests++; if (imem_addr !== 18'h74 || busy !== 1'b1 || halted !== 1'b0 || instr_valid !== 1'b1) begin nfail++; $display("FAIL fin_drain: got a%h b%b h%b v%b want 74 1 0 1", imem_addr, busy, halted, instr_valid); end
    redirect = 1'b1; redirect_pc = 18'h20; step(); redirect = 1'b0;
    ntests++; if (halted !== 1'b0 || busy !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 18'h20) begin nfail++; $display("FAIL fin_redir: got h%b b%b v%b a%h want 0 1 0 20", halted, busy, instr_valid, imem_addr); end
    got_pc.delete(); got_in.delete();
    instr_ready = 1'b1; step(); step();
    ntests++; if (got_pc.size() != 1 || got_pc[0] !== 18'h20) begin nfail++; $display("FAIL fin_redir_first: got n%0d pc%h want 1 20", got_pc.size(), got_pc.size() > 0 ? got_pc[0] : 18'h0); end
    seen = 1'b0; pre_h = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      pf = instr_valid && instr_ready && (instr_pc === 18'h74);
      pre_h = halted;
      step();
      seen = pf;
    end
    ntests++; if (!seen) begin nfail++; $display("FAIL fin_pop_timeout: got no FINISH pop want one"); end
    ntests++; if (pre_h !== 1'b0 || halted !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0) begin nfail++; $display("FAIL fin_halt: got pre%b h%b b%b v%b want 0 1 0 0", pre_h, halted, busy, instr_valid); end
    ntests++; if (got_in.size() == 0 || got_in[got_in.size()-1] !== FIN_WORD) begin nfail++; $display("FAIL fin_word: got %h want %h", got_in.size() > 0 ? got_in[got_in.size()-1] : 18'h0, FIN_WORD); end
  endtask

  task automatic test_restart();
    finish_idx = -1;
    start = 1'b1; step(); start = 1'b0;
    ntests++; if (busy !== 1'b1 || halted !== 1'b0 || imem_addr !== 18'h0) begin nfail++; $display("FAIL rs_state: got b%b h%b a%h want 1 0 0", busy, halted, imem_addr); end
    step();
    ntests++; if (instr_valid !== 1'b1 || instr_pc !== 18'h0) begin nfail++; $display("FAIL rs_first: got v%b pc%h want 1 0", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    instr_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
    step(); step();
    redirect = 1'b1; redirect_pc = 18'h3FFFD; step(); redirect = 1'b0;
    ntests++; if (imem_addr !== 18'h3FFFC) begin nfail++; $display("FAIL wr_target: got %h want 3fffc", imem_addr); end
    got_pc.delete(); got_in.delete();
    exp_pc.delete(); exp_in.delete();
    expect_pc(18'h3FFFC); expect_pc(18'h0);
    step();
    ntests++; if (imem_addr !== 18'h0) begin nfail++; $display("FAIL wr_addr: got %h want 0", imem_addr); end
    step(); step();
    ntests++; if (got_pc.size() != 2) begin nfail++; $display("FAIL wr_count: got %0d want 2", got_pc.size()); end
    for (int i = 0; i < 2 && i < got_pc.size(); i++) begin
      ntests++; if (got_pc[i] !== exp_pc[i]) begin nfail++; $display("FAIL wr_item%0d: got %h want %h", i, got_pc[i], exp_pc[i]); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    ntests++; if (instr_valid !== 1'b1 || imem_addr !== 18'h8) begin nfail++; $display("FAIL ar_full: got v%b a%h want 1 8", instr_valid, imem_addr); end
    #2 reset = 1'b1;
    #1;
    ntests++; if (instr_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || imem_addr !== 18'h0) begin nfail++; $display("FAIL ar_flags: got v%b b%b h%b a%h want 0 0 0 0", instr_valid, busy, halted, imem_addr); end
    ntests++; if (instr !== 18'h0 || instr_pc !== 18'h0) begin nfail++; $display("FAIL ar_head: got %h@%h want 0@0", instr, instr_pc); end
    @(negedge clk);
    step();
    reset = 1'b0;
    got_pc.delete(); got_in.delete();
    instr_ready = 1'b1;
    step();
    ntests++; if (got_pc.size() != 0) begin nfail++; $display("FAIL ar_quiet: got %0d items want 0", got_pc.size()); end
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    ntests++; if (got_pc.size() != 1 || got_pc[0] !== 18'h0) begin nfail++; $display("FAIL ar_restart: got n%0d pc%h want 1 0", got_pc.size(), got_pc.size() > 0 ? got_pc[0] : 18'h0); end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect();
    test_finish();
    test_restart();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
